// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply / divide unit. One iteration per clock. Multiply and
// divide both work on operand magnitudes, and the sign is fixed up in the
// same edge that writes the result.
//   MULT/MULTU : shift-add over WIDTH cycles, giving {hi,lo} = a*b.
//   DIV/DIVU   : restoring division over WIDTH cycles, giving lo = quotient
//                and hi = remainder. Signed division truncates toward zero.
//   Divide by zero: one pass through DIV with no iteration, then done with
//   div_zero=1. hi/lo keep their previous values.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   start    in   begin an operation (sampled only while busy=0)
//   op       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     in   multiplicand/dividend, multiplier/divisor
//   busy     out  high in states MUL and DIV
//   done     out  one-cycle completion pulse (state FINISH)
//   div_zero out  divide-by-zero flag, valid with done
//   hi, lo   out  product high/low half, or remainder/quotient
//   counter  out  iterations remaining
// ----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [CW-1:0]    counter
);

    localparam int W = WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t         state_q;
    logic [2*W-1:0] work_q;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [W-1:0]   m_q;         // multiplicand or divisor magnitude
    logic           neg_res_q;   // product/quotient must be negated
    logic           neg_rem_q;   // remainder must be negated (dividend negative)
    logic           dz_pend_q;   // divide by zero detected at accept
    logic           busy_q;
    logic           done_q;
    logic           div_zero_q;
    logic [W-1:0]   hi_q;
    logic [W-1:0]   lo_q;
    logic [CW-1:0]  counter_q;

    logic           a_neg_s;
    logic           b_neg_s;
    logic [W-1:0]   a_mag_s;
    logic [W-1:0]   b_mag_s;
    logic           b_zero_s;
    logic [W-1:0]   mul_add_s;
    logic [W:0]     mul_sum_s;
    logic [W:0]     rem_shift_s;
    logic           div_ge_s;
    logic [W-1:0]   div_rem_s;
    logic [2*W-1:0] step_s;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   res_hi_s;
    logic [W-1:0]   res_lo_s;

    // Operand magnitudes and signs at accept; op[0]=1 selects unsigned.
    always_comb begin
        a_neg_s  = ~op[0] & a[W-1];
        b_neg_s  = ~op[0] & b[W-1];
        a_mag_s  = a_neg_s ? -a : a;
        b_mag_s  = b_neg_s ? -b : b;
        b_zero_s = (b == {W{1'b0}});
    end

    // One iteration step, plus the sign-corrected result written on the last step.
    always_comb begin
        mul_add_s   = work_q[0] ? m_q : {W{1'b0}};
        mul_sum_s   = {1'b0, work_q[2*W-1:W]} + {1'b0, mul_add_s};
        // The shifted remainder can need W+1 bits. After a successful subtract
        // it is below the divisor, so a W-bit difference is exact.
        rem_shift_s = {work_q[2*W-1:W], work_q[W-1]};
        div_ge_s    = (rem_shift_s >= {1'b0, m_q});
        if (div_ge_s) begin
            div_rem_s = rem_shift_s[W-1:0] - m_q;
        end else begin
            div_rem_s = rem_shift_s[W-1:0];
        end
        if (state_q == DIV) begin
            step_s   = {div_rem_s, work_q[W-2:0], div_ge_s};
            prod_s   = step_s;
            res_lo_s = neg_res_q ? -step_s[W-1:0]   : step_s[W-1:0];
            res_hi_s = neg_rem_q ? -step_s[2*W-1:W] : step_s[2*W-1:W];
        end else begin
            step_s   = {mul_sum_s, work_q[W-1:1]};
            prod_s   = neg_res_q ? -step_s : step_s;
            res_lo_s = prod_s[W-1:0];
            res_hi_s = prod_s[2*W-1:W];
        end
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            work_q     <= {(2*W){1'b0}};
            m_q        <= {W{1'b0}};
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_pend_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= {W{1'b0}};
            lo_q       <= {W{1'b0}};
            counter_q  <= {CW{1'b0}};
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= op[1] ? DIV : MUL;
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        counter_q  <= CW'(WIDTH);
                        dz_pend_q  <= op[1] & b_zero_s;
                        neg_res_q  <= a_neg_s ^ b_neg_s;
                        neg_rem_q  <= a_neg_s;
                        if (op[1]) begin
                            m_q    <= b_mag_s;
                            work_q <= {{W{1'b0}}, a_mag_s};
                        end else begin
                            m_q    <= a_mag_s;
                            work_q <= {{W{1'b0}}, b_mag_s};
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MUL, DIV: begin
                    if (dz_pend_q) begin
                        // Divide by zero: finish without iterating and leave hi/lo alone.
                        state_q    <= FINISH;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        div_zero_q <= 1'b1;
                        dz_pend_q  <= 1'b0;
                        counter_q  <= {CW{1'b0}};
                    end else begin
                        work_q    <= step_s;
                        counter_q <= counter_q - CW'(1);
                        if (counter_q == CW'(1)) begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            hi_q    <= res_hi_s;
                            lo_q    <= res_lo_s;
                        end else begin
                            state_q <= state_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign counter  = counter_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed bench for muldiv_unit. It drives a WIDTH=32 instance and a
// WIDTH=8 instance. Every expected value below is hand-computed.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;

    logic        clock;
    logic        reset;

    logic        start32;
    logic [1:0]  op32;
    logic [31:0] a32, b32;
    logic        busy32, done32, dz32;
    logic [31:0] hi32, lo32;
    logic [5:0]  cnt32;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;
    logic [3:0]  cnt8;

    int errors;
    int checks;
    int lat;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32), .counter(cnt32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8), .counter(cnt8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Issue one operation on the 32-bit unit. The caller is 1 time unit after
    // a posedge. Returns the number of edges after the start edge until done
    // is seen, or 41 on timeout.
    task automatic do_op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int latency);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(posedge clock); #1;
        start32 = 1'b0;
        latency = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (done32) begin
                latency = i;
                break;
            end
        end
    endtask

    task automatic do_op8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int latency);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(posedge clock); #1;
        start8 = 1'b0;
        latency = 17;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clock); #1;
            if (done8) begin
                latency = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #2;
        checks++; if ({hi32, lo32} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi32, lo32}); end
        checks++; if ({busy32, done32, dz32} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy32, done32, dz32}); end
        checks++; if (cnt32 !== 6'd0) begin errors++; $display("FAIL reset_counter: got %0d expected 0", cnt32); end
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_mult;
        // MULT -3 * 7 = -21
        start32 = 1'b1; op32 = 2'b00; a32 = 32'hFFFF_FFFD; b32 = 32'h0000_0007;
        @(posedge clock); #1;
        start32 = 1'b0;
        checks++; if (cnt32 !== 6'd32) begin errors++; $display("FAIL mult_counter_load: got %0d expected 32", cnt32); end
        checks++; if (busy32 !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b expected 1", busy32); end
        lat = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (done32) begin lat = i; break; end
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL mult_latency: got %0d expected 32", lat); end
        checks++; if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_signed: got %h expected FFFFFFFFFFFFFFEB", {hi32, lo32}); end
        checks++; if ({busy32, cnt32} !== 7'd0) begin errors++; $display("FAIL mult_finish_state: got busy=%b cnt=%0d expected 0/0", busy32, cnt32); end
        // done is a single pulse and the result holds afterwards
        @(posedge clock); #1;
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done32); end
        @(posedge clock); #1;
        checks++; if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL result_hold: got %h expected FFFFFFFFFFFFFFEB", {hi32, lo32}); end
        // MULTU FFFFFFFF^2
        do_op32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL multu_latency: got %0d expected 32", lat); end
        checks++; if ({hi32, lo32} !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL multu: got %h expected FFFFFFFE00000001", {hi32, lo32}); end
    endtask

    task automatic test_div;
        do_op32(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat);
        checks++; if (lat !== 32) begin errors++; $display("FAIL div_latency: got %0d expected 32", lat); end
        checks++; if ({hi32, lo32} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_signed: got hi=%h lo=%h expected FFFFFFFF/FFFFFFFD", hi32, lo32); end
        checks++; if (dz32 !== 1'b0) begin errors++; $display("FAIL div_dz_flag: got %b expected 0", dz32); end
        do_op32(2'b11, 32'd7, 32'd2, lat);
        checks++; if ({hi32, lo32} !== {32'd1, 32'd3}) begin errors++; $display("FAIL divu: got hi=%h lo=%h expected 1/3", hi32, lo32); end
    endtask

    task automatic test_div_zero;
        // hi=1, lo=3 are left over from DIVU 7/2
        do_op32(2'b11, 32'd55, 32'd0, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        checks++; if (dz32 !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", dz32); end
        checks++; if ({hi32, lo32} !== {32'd1, 32'd3}) begin errors++; $display("FAIL dz_hold: got hi=%h lo=%h expected 1/3", hi32, lo32); end
        // DIV most-negative / -1, started in the done cycle; div_zero must clear on accept
        start32 = 1'b1; op32 = 2'b10; a32 = 32'h8000_0000; b32 = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        start32 = 1'b0;
        checks++; if (dz32 !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b expected 0", dz32); end
        lat = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (done32) begin lat = i; break; end
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL minneg_latency: got %0d expected 32", lat); end
        checks++; if ({hi32, lo32, dz32} !== {32'h0, 32'h8000_0000, 1'b0}) begin errors++; $display("FAIL minneg_div: got hi=%h lo=%h dz=%b expected 0/80000000/0", hi32, lo32, dz32); end
    endtask

    task automatic test_back_to_back;
        int cnt;
        start32 = 1'b1; op32 = 2'b00; a32 = 32'd5; b32 = 32'd6;
        @(posedge clock); #1;
        start32 = 1'b0;
        lat = 41;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            start32 = 1'b0;
            cnt++;
            if (cnt == 10) begin
                // intrusive start while busy, expected to be ignored
                start32 = 1'b1; op32 = 2'b01; a32 = 32'd100; b32 = 32'd100;
            end
            if (done32) begin lat = i; break; end
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL ignore_latency: got %0d expected 32", lat); end
        checks++; if ({hi32, lo32} !== 64'd30) begin errors++; $display("FAIL ignore_start: got %h expected 30", {hi32, lo32}); end
        // start during the done cycle is accepted
        start32 = 1'b1; op32 = 2'b01; a32 = 32'h0001_0000; b32 = 32'h0001_0000;
        @(posedge clock); #1;
        start32 = 1'b0;
        checks++; if ({done32, busy32, cnt32} !== {1'b0, 1'b1, 6'd32}) begin errors++; $display("FAIL b2b_accept: got done=%b busy=%b cnt=%0d expected 0/1/32", done32, busy32, cnt32); end
        lat = 41;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (done32) begin lat = i; break; end
        end
        checks++; if (lat !== 32) begin errors++; $display("FAIL b2b_latency: got %0d expected 32", lat); end
        checks++; if ({hi32, lo32} !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL b2b_result: got %h expected 0000000100000000", {hi32, lo32}); end
    endtask

    task automatic test_reset_midop;
        int seen_done;
        start32 = 1'b1; op32 = 2'b10; a32 = 32'd100; b32 = 32'd7;
        @(posedge clock); #1;
        start32 = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(posedge clock); #1;
        end
        reset = 1'b0;
        #1;
        checks++; if ({hi32, lo32, cnt32, busy32, done32, dz32} !== 73'd0) begin errors++; $display("FAIL midop_reset: got hi=%h lo=%h cnt=%0d busy=%b done=%b dz=%b expected all 0", hi32, lo32, cnt32, busy32, done32, dz32); end
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            if (done32) seen_done = 1;
        end
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (done32) seen_done = 1;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL midop_no_done: got %0d expected 0", seen_done); end
        do_op32(2'b11, 32'd7, 32'd2, lat);
        checks++; if ({lat, hi32, lo32} !== {32'd32, 32'd1, 32'd3}) begin errors++; $display("FAIL post_reset_op: got lat=%0d hi=%h lo=%h expected 32/1/3", lat, hi32, lo32); end
    endtask

    task automatic test_width8;
        do_op8(2'b00, 8'hFD, 8'h07, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL w8_latency: got %0d expected 8", lat); end
        checks++; if ({hi8, lo8} !== 16'hFFEB) begin errors++; $display("FAIL w8_mult: got %h expected FFEB", {hi8, lo8}); end
        do_op8(2'b01, 8'hFF, 8'hFF, lat);
        checks++; if ({hi8, lo8} !== 16'hFE01) begin errors++; $display("FAIL w8_multu: got %h expected FE01", {hi8, lo8}); end
        do_op8(2'b10, 8'hF9, 8'h02, lat);
        checks++; if ({hi8, lo8} !== 16'hFFFD) begin errors++; $display("FAIL w8_div: got hi=%h lo=%h expected FF/FD", hi8, lo8); end
        do_op8(2'b11, 8'h07, 8'h02, lat);
        checks++; if ({hi8, lo8} !== 16'h0103) begin errors++; $display("FAIL w8_divu: got hi=%h lo=%h expected 01/03", hi8, lo8); end
        do_op8(2'b10, 8'h80, 8'hFF, lat);
        checks++; if ({hi8, lo8, dz8} !== {8'h00, 8'h80, 1'b0}) begin errors++; $display("FAIL w8_minneg: got hi=%h lo=%h dz=%b expected 00/80/0", hi8, lo8, dz8); end
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b0;
        start32 = 1'b0; op32 = 2'b00; a32 = 32'd0; b32 = 32'd0;
        start8  = 1'b0; op8  = 2'b00; a8  = 8'd0;  b8  = 8'd0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_midop();
        test_width8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits (legal range 4..64).
REQ-002 SHALL have parameter: CW, $clog2(WIDTH)+1, width of the iteration counter output.
REQ-003 SHALL have port: clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  in  1  request to begin an operation; sampled only when busy=0.
REQ-006 SHALL have port: op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 SHALL have port: a  in  WIDTH  multiplicand / dividend.
REQ-008 SHALL have port: b  in  WIDTH  multiplier / divisor.
REQ-009 SHALL have port: busy  out  1  high while iterating (states MUL, DIV).
REQ-010 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port: div_zero  out  1  divide by zero flag, valid with done.
REQ-012 SHALL have port: hi  out  WIDTH  product upper half / remainder.
REQ-013 SHALL have port: lo  out  WIDTH  product lower half / quotient.
REQ-014 SHALL have port: counter  out  CW  iterations remaining.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FINISH.
REQ-016 SHALL, on a rising edge with start=1 and busy=0 (IDLE or FINISH), latch a, b, op and load counter=WIDTH.
- Next state: MUL for op[1]=0; DIV for op[1]=1.
REQ-017 SHALL ignore start while busy=1; latched operands are unaffected by later changes on a/b/op.
REQ-018 SHALL perform one iteration per cycle in MUL/DIV, decrementing counter; when counter reaches 0 the state becomes FINISH and hi/lo are written at that same edge.
REQ-019 SHALL, with start sampled at edge n, update hi/lo and raise done for the cycle after edge n+WIDTH (DIV by zero excepted, REQ-024).
REQ-020 SHALL assert done only in FINISH; FINISH returns to IDLE next edge unless a new start is accepted.
REQ-021 SHALL produce the full 2*WIDTH-bit product for multiply: {hi,lo}=a*b.
- Signed for MULT (Booth radix-2 or equivalent); unsigned for MULTU.
REQ-022 SHALL produce restoring division on magnitudes for divide: lo=quotient, hi=remainder.
- DIV: quotient negated when operand signs differ; remainder takes the dividend's sign (truncation toward zero).
REQ-023 SHALL yield, for DIV of most-negative by -1: lo=most-negative value, hi=0, div_zero=0.
REQ-024 SHALL, for DIV/DIVU with b=0: skip iteration, go to FINISH after the start edge (done in cycle after edge n+1), set div_zero=1, and leave hi/lo unchanged.
REQ-025 SHALL clear div_zero when the next operation is accepted.
REQ-026 SHALL hold hi/lo stable between completions.

Reset
REQ-027 SHALL, while reset=0, asynchronously force: state IDLE, hi=0, lo=0, counter=0, busy=0, done=0, div_zero=0.
REQ-028 SHALL abort any in-flight operation on reset with no done pulse; the first start after reset release behaves per REQ-016.

Verification (WIDTH=32 unless noted)
REQ-029 SHALL verify MULT a=FFFFFFFD (-3), b=00000007 -> done 32 cycles after start edge, hi=FFFFFFFF, lo=FFFFFFEB; MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-030 SHALL verify DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-031 SHALL verify DIVU with b=0 and prior hi=1, lo=3 -> done one cycle after start, div_zero=1, hi=1, lo=3; next valid start clears div_zero.
REQ-032 SHALL verify DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
REQ-033 SHALL verify that start with new operands at cycle 10 of a MULT is ignored; back-to-back start during the done cycle is accepted, and the second result appears 32 cycles later.
REQ-034 SHALL verify reset=0 at cycle 15 of a DIV -> all outputs 0 immediately, no done. Repeat REQ-029/030 cases with WIDTH=8 (e.g. MULT FD*07 -> hi=FF, lo=EB).
